// File: rtl/roteador_pacotes_if.sv
// Handshake and control bundle for the packet router: N input streams,
// one registered output stream, select/mode controls and status.
interface roteador_pacotes_if #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned N_CH     = 4,
    parameter int unsigned SEL_BITS = 2
);
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_last;
    logic [N_CH-1:0]       in_ready;
    logic                  mode;
    logic [SEL_BITS-1:0]   SEL;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;
    logic [SEL_BITS-1:0]   grant;
    logic                  busy;

    modport master (
        output in_data, in_valid, in_last, mode, SEL, out_ready,
        input  in_ready, out_data, out_valid, out_last, grant, busy
    );

    modport slave (
        input  in_data, in_valid, in_last, mode, SEL, out_ready,
        output in_ready, out_data, out_valid, out_last, grant, busy
    );
endinterface

// File: rtl/roteador_pacotes.sv
// N-channel packet router: fixed-select or round-robin arbitration, grant held
// for a whole packet, single registered output stage with valid/ready.
module roteador_pacotes #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned N_CH     = 4,
    parameter int unsigned SEL_BITS = 2
) (
    input  logic               clock,
    input  logic               reset,
    roteador_pacotes_if.slave  bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [SEL_BITS-1:0] lock_q, lock_d;
    logic [SEL_BITS-1:0] rr_q, rr_d;
    logic [SEL_BITS-1:0] grant_q, grant_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;

    logic [SEL_BITS-1:0] cand, scan_idx, sel_ch;
    logic                cand_ok, sel_ok, can_accept, xfer, beat_last;
    logic [WIDTH-1:0]    beat_data;
    logic [N_CH-1:0]     ready_c;

    // Candidate for a new packet: clamped SEL, or first valid channel after rr_q
    always_comb begin
        cand     = '0;
        cand_ok  = 1'b0;
        scan_idx = '0;
        if (!bus.mode) begin
            cand_ok = 1'b1;
            cand    = (32'(bus.SEL) >= N_CH) ? SEL_BITS'(N_CH - 1) : bus.SEL;
        end else begin
            for (int unsigned k = 1; k <= N_CH; k++) begin
                scan_idx = SEL_BITS'((32'(rr_q) + k) % N_CH);
                if (!cand_ok && bus.in_valid[scan_idx]) begin
                    cand    = scan_idx;
                    cand_ok = 1'b1;
                end
            end
        end
    end

    // An open packet pins the source; otherwise the candidate is offered
    always_comb begin
        sel_ch     = (state_q == LOCKED) ? lock_q : cand;
        sel_ok     = (state_q == LOCKED) || cand_ok;
        can_accept = !valid_q || bus.out_ready;
        ready_c    = '0;
        if (can_accept && !reset && sel_ok) begin
            ready_c[sel_ch] = 1'b1;
        end
        beat_data = bus.in_data[32'(sel_ch)*WIDTH +: WIDTH];
        beat_last = bus.in_last[sel_ch];
        xfer      = bus.in_valid[sel_ch] && ready_c[sel_ch];
    end

    // Next state and output-stage update
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q && !bus.out_ready;
        busy_d  = busy_q;

        if (xfer) begin
            data_d  = beat_data;
            last_d  = beat_last;
            valid_d = 1'b1;
            grant_d = sel_ch;
        end

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (bus.mode) begin
                        rr_d = sel_ch;
                    end
                    if (!beat_last) begin
                        state_d = LOCKED;
                        lock_d  = sel_ch;
                    end
                end
            end
            LOCKED: begin
                if (xfer && beat_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == LOCKED);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            lock_q  <= '0;
            rr_q    <= SEL_BITS'(N_CH - 1);
            grant_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_roteador_pacotes.sv
// Bench for roteador_pacotes: directed scenarios plus randomized traffic,
// all checked against a packet-level reference model.
module tb_roteador_pacotes;
    localparam int WIDTH    = 4;
    localparam int N_CH     = 4;
    localparam int SEL_BITS = 2;

    typedef struct packed {logic [3:0] d; logic l;} beat_t;
    typedef struct packed {logic [3:0] d; logic [1:0] g;} obs_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    roteador_pacotes_if #(.WIDTH(WIDTH), .N_CH(N_CH), .SEL_BITS(SEL_BITS)) bus ();
    roteador_pacotes #(.WIDTH(WIDTH), .N_CH(N_CH), .SEL_BITS(SEL_BITS)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    beat_t src_q[N_CH][$];
    obs_t  log_q[$];
    int    valid_prob = 100;
    int    ready_prob = 100;
    bit    refill     = 1'b0;

    logic                  mode_v = 1'b0;
    logic [SEL_BITS-1:0]   sel_v  = '0;
    logic [N_CH-1:0]       valid_v, last_v;
    logic [N_CH*WIDTH-1:0] data_v;
    logic                  ready_v;

    // Reference model: owner of the open packet (-1 = none), last round-robin winner, output register
    int         m_owner, m_rr, m_grant, pick_ch;
    bit         m_ov, m_ol;
    logic [3:0] m_od;
    logic [N_CH-1:0] exp_ready;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_rr    = N_CH - 1;
        m_grant = 0;
        m_ov    = 1'b0;
        m_ol    = 1'b0;
        m_od    = '0;
    endtask

    function automatic int pick();
        if (m_owner >= 0) return m_owner;
        if (!mode_v) return (int'(sel_v) < N_CH) ? int'(sel_v) : N_CH - 1;
        for (int s = 1; s <= N_CH; s++) begin
            if (valid_v[(m_rr + s) % N_CH]) return (m_rr + s) % N_CH;
        end
        return -1;
    endfunction

    function automatic bit sources_pending();
        for (int i = 0; i < N_CH; i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_pkt(input int ch, input logic [31:0] beats, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.d = beats[4*k +: 4];
            b.l = (k == n - 1);
            src_q[ch].push_back(b);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N_CH; i++) begin
            if (refill && src_q[i].size() == 0) begin
                int n;
                n = int'($urandom_range(1, 4));
                push_pkt(i, $urandom, n);
            end
            if (src_q[i].size() > 0) begin
                valid_v[i] = ($urandom_range(0, 99) < valid_prob);
                data_v[i*WIDTH +: WIDTH] = src_q[i][0].d;
                last_v[i] = src_q[i][0].l;
            end else begin
                valid_v[i] = 1'b0;
                data_v[i*WIDTH +: WIDTH] = 4'($urandom);
                last_v[i] = 1'($urandom);
            end
        end
        ready_v       = ($urandom_range(0, 99) < ready_prob);
        bus.in_valid  = valid_v;
        bus.in_data   = data_v;
        bus.in_last   = last_v;
        bus.mode      = mode_v;
        bus.SEL       = sel_v;
        bus.out_ready = ready_v;
    endtask

    task automatic cycle();
        obs_t o;
        drive();
        @(negedge clock);
        pick_ch   = pick();
        exp_ready = '0;
        if (!reset && (!m_ov || ready_v) && pick_ch >= 0) exp_ready[pick_ch] = 1'b1;
        check("in_ready",  32'(bus.in_ready),  32'(exp_ready));
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("out_data",  32'(bus.out_data),  32'(m_od));
        check("out_last",  32'(bus.out_last),  32'(m_ol));
        check("grant",     32'(bus.grant),     32'(m_grant));
        check("busy",      32'(bus.busy),      32'(m_owner >= 0));
        if (bus.out_valid && ready_v) begin
            o.d = bus.out_data;
            o.g = bus.grant;
            log_q.push_back(o);
        end
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            if (m_ov && ready_v) m_ov = 1'b0;
            if (pick_ch >= 0 && exp_ready[pick_ch] && valid_v[pick_ch]) begin
                m_od    = data_v[pick_ch*WIDTH +: WIDTH];
                m_ol    = last_v[pick_ch];
                m_ov    = 1'b1;
                m_grant = pick_ch;
                if (m_owner < 0) begin
                    if (mode_v) m_rr = pick_ch;
                    if (!m_ol) m_owner = pick_ch;
                end else if (m_ol) begin
                    m_owner = -1;
                end
                void'(src_q[pick_ch].pop_front());
            end
        end
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sources_pending() || m_ov) && n < 300) begin
            cycle();
            n++;
        end
        check("drain_timeout", 32'(n >= 300), 32'd0);
    endtask

    // Observed output beats, in order, against packed nibble sequences
    task automatic expect_log(input string tag, input int n, input logic [31:0] dseq, input logic [31:0] gseq);
        check({tag, "_count"}, 32'(log_q.size()), 32'(n));
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            check({tag, "_data"},  32'(log_q[i].d), 32'(dseq[4*i +: 4]));
            check({tag, "_grant"}, 32'(log_q[i].g), 32'(gseq[4*i +: 2]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;

        // Fixed select, single beat on ch2
        mode_v = 1'b0; sel_v = 2'd2;
        log_q.delete();
        push_pkt(2, 32'hA, 1);
        drive();
        #1;
        check("s1_in_ready", 32'(bus.in_ready), 32'b0100);
        cycle();
        check("s1_out_valid", 32'(bus.out_valid), 32'd1);
        check("s1_out_data",  32'(bus.out_data),  32'hA);
        check("s1_out_last",  32'(bus.out_last),  32'd1);
        check("s1_grant",     32'(bus.grant),     32'd2);
        check("s1_busy",      32'(bus.busy),      32'd0);
        drain();
        expect_log("s1", 1, 32'hA, 32'h2);

        // Round-robin over four single-beat packets, then wrap to ch0
        mode_v = 1'b1;
        log_q.delete();
        push_pkt(0, 32'h1, 1); push_pkt(0, 32'h5, 1);
        push_pkt(1, 32'h2, 1); push_pkt(2, 32'h3, 1); push_pkt(3, 32'h4, 1);
        drain();
        expect_log("s2", 5, 32'h54321, 32'h03210);

        // 3-beat packet on ch1 is not interleaved; next grant scans from ch2
        log_q.delete();
        push_pkt(1, 32'h765, 3); push_pkt(0, 32'h8, 1); push_pkt(3, 32'h9, 1);
        drain();
        expect_log("s3", 5, 32'h89765, 32'h03111);

        // Backpressure holds the output beat and blocks the input
        mode_v = 1'b0; sel_v = 2'd2;
        log_q.delete();
        push_pkt(2, 32'hDC, 2);
        cycle();
        ready_prob = 0;
        repeat (3) cycle();
        check("s4_hold_data", 32'(bus.out_data), 32'hC);
        check("s4_in_ready",  32'(bus.in_ready), 32'd0);
        ready_prob = 100;
        drain();
        expect_log("s4", 2, 32'hDC, 32'h22);

        // SEL change mid-packet is ignored until the last beat
        sel_v = 2'd1;
        log_q.delete();
        push_pkt(1, 32'h321, 3); push_pkt(3, 32'hE, 1);
        cycle();
        sel_v = 2'd3;
        drain();
        expect_log("s5", 4, 32'hE321, 32'h3111);

        // Reset while locked discards the beat and lock, restores rr start
        mode_v = 1'b1;
        push_pkt(2, 32'hDCBA, 4);
        cycle();
        cycle();
        check("s6_busy_pre", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("s6_out_valid", 32'(bus.out_valid), 32'd0);
        check("s6_busy",      32'(bus.busy),      32'd0);
        check("s6_grant",     32'(bus.grant),     32'd0);
        src_q[2].delete();
        log_q.delete();
        push_pkt(0, 32'h1, 1); push_pkt(1, 32'h2, 1); push_pkt(3, 32'h3, 1);
        drain();
        expect_log("s6", 3, 32'h321, 32'h310);

        // Randomized traffic with mode/SEL churn, gaps, stalls and rare resets
        refill = 1'b1; valid_prob = 70; ready_prob = 70;
        repeat (500) begin
            if ($urandom_range(0, 99) < 4)  mode_v = ~mode_v;
            if ($urandom_range(0, 99) < 10) sel_v = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 199) == 0);
            cycle();
            reset = 1'b0;
        end
        refill = 1'b0; mode_v = 1'b1; valid_prob = 100; ready_prob = 100;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/roteador_pacotes.md
Name: roteador_pacotes

Overview:
- Parametrised N-channel packet router; successor to the combinational 4:1 word selector.
- Selects one of N_CH input streams and forwards it through a registered output stage with valid/ready handshakes.
- Supports fixed-select mode (SEL-driven) or round-robin mode.
- Holds the grant for the whole packet: from first beat through the beat flagged last.

Parameters:
- WIDTH, 4, data bits per beat.
- N_CH, 4, number of input channels (2..16).
- SEL_BITS, 2, select/grant width; must equal ceil(log2(N_CH)).

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel beat valid.
- in_last  input  N_CH  per-channel end-of-packet flag, qualified by in_valid.
- in_ready  output  N_CH  per-channel beat accepted this cycle (combinational).
- mode  input  1  0 = fixed select via SEL; 1 = round-robin.
- SEL  input  SEL_BITS  channel choice in mode 0.
- out_data  output  WIDTH  registered output beat.
- out_valid  output  1  out_data/out_last valid.
- out_last  output  1  end-of-packet flag for the output beat.
- out_ready  input  1  downstream accepts the beat.
- grant  output  SEL_BITS  channel currently owning the output; registered.
- busy  output  1  high while a packet is open (state LOCKED).

Behaviour:
- Sync reset (all registers): out_valid=0, out_data=0, out_last=0, grant=0, busy=0, state=IDLE, rr_ptr=N_CH-1 (first round-robin pick is channel 0). in_ready=0 during reset.
- Reset mid-packet discards the held output beat and the lock. No partial packet resumes.
- Output stage is a single register.
  - can_accept = !out_valid | out_ready.
  - Latency: a beat accepted at edge k appears on out_* after edge k (1 cycle).
  - Throughput: 1 beat/cycle while out_ready stays high.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_last and grant hold stable.
- Candidate channel c, computed in IDLE:
  - mode 0: c = SEL. If SEL >= N_CH, c = N_CH-1 (default arm).
  - mode 1: first channel with in_valid=1, scanning cyclically from rr_ptr+1. If no channel is valid, there is no candidate.
- in_ready[i] = can_accept & !reset & (state==LOCKED ? i==lock_ch : i==c). All other bits are 0.
- A transfer occurs when in_valid[g] & in_ready[g]. On transfer:
  - out_data <= that channel's beat; out_last <= in_last[g]; out_valid <= 1; grant <= g.
  - In mode 1, rr_ptr <= g on the first beat of each packet.
- State machine:
  - IDLE -> LOCKED: on a transfer with in_last=0; lock_ch <= g; busy <= 1.
  - IDLE -> IDLE: on a transfer with in_last=1 (single-beat packet).
  - LOCKED -> IDLE: on a transfer from lock_ch with in_last=1; busy <= 0 on the same edge.
  - In LOCKED, changes on mode, SEL and other channels' in_valid are ignored. Other channels see in_ready=0 (no interleaving).
- Simultaneous drain and refill (out_valid=1, out_ready=1, new transfer on the same edge): the new beat replaces the old one with no bubble.
- Output drained with no transfer: out_valid <= 0; out_data/out_last hold their last value.
- Mode 0 with the selected channel idle: no transfer. Other valid channels wait and are never granted implicitly.
- No data width conversion: WIDTH in equals WIDTH out, bit-exact.

Test Plan:
- Reset then mode=0, SEL=2, in_valid=4'b0100, ch2 data=4'hA, in_last=1, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=4'hA, out_last=1, grant=2, busy=0.
- mode=1, all four channels valid with single-beat packets 1,2,3,4, out_ready=1 -> outputs 1,2,3,4 on consecutive cycles; grant sequence 0,1,2,3, then wraps back to 0.
- mode=1, ch1 sends a 3-beat packet (5,6,7; last on 7) while ch0 and ch3 stay valid -> output is 5,6,7 uninterrupted; busy=1 for the first two beats; next grant is 3 (scan from rr_ptr=1).
- Backpressure: out_ready=0 for 3 cycles after the first beat of 4'hC -> out_data stays 4'hC and in_ready=0; then out_ready=1 -> the next beat follows with no loss or duplication.
- mode=0, SEL=1 with lock held on ch1; SEL changed to 3 mid-packet -> the packet on ch1 completes; ch3 is granted only after ch1's last beat.
- Assert reset while LOCKED with out_valid=1 -> next cycle out_valid=0, busy=0, grant=0; the first mode-1 grant after reset goes to channel 0.
